byte_word_packer: RTL and testbench
===================================

Name: byte_word_packer

Overview:
- Downstream stage of the 4-channel round-robin FIFO arbiter.
- Consumes the arbiter's 8-bit dout/valid byte stream (at most one byte per cycle, no backpressure) and packs consecutive bytes into 32-bit words.
- Queues packed words in a small output FIFO that drives a valid/ready handshake toward the next consumer.
- Supports a flush to emit a partial word, and flags words lost to output-queue overflow.

Parameters:
- DEPTH, 4, number of 32-bit word entries in the output queue; power of two, minimum 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  byte strobe; connect to arbiter valid.
- in_data  input  8  byte; connect to arbiter dout. Ignored (may be X) when in_valid=0.
- flush  input  1  single-cycle request to emit a partially assembled word.
- out_ready  input  1  downstream accepts the word on out_data this cycle.
- out_valid  output  1  queue head is valid.
- out_data  output  32  queue head word.
- out_keep  output  4  byte-valid mask of the queue head; bit i covers out_data[8i+7:8i].
- overflow  output  1  sticky flag: at least one word has been dropped.

Behaviour:
- Reset, synchronous with rst=1 at a rising edge:
  - byte count, assembly register, queue pointers and occupancy are cleared.
  - overflow=0, out_valid=0, out_data=0, out_keep=0 the cycle after reset.
  - Reset mid-word or mid-queue discards all pending data silently; overflow is not set.
- Assembly:
  - A 2-bit byte count cnt (0..3) and a 32-bit assembly register.
  - Byte order is little-endian: the first byte lands in [7:0], the fourth in [31:24].
  - An accepted byte with cnt<3 writes lane cnt and increments cnt.
  - An accepted byte with cnt=3 pushes the word with keep=4'b1111 and resets cnt to 0.
  - Unfilled lanes of a pushed word are zero; the assembly register is cleared after every push.
- Flush:
  - flush=1 with cnt>0: the partial word is pushed with keep = (1<<cnt)-1, and cnt is reset to 0.
  - flush=1 with in_valid=1 in the same cycle: the byte is merged first, then the result is pushed with keep reflecting cnt+1 bytes. This gives one push, never two.
  - flush=1 with cnt=0 and in_valid=0: no operation.
- Latency: a pushed word appears on out_valid/out_data in the cycle after the edge on which its last byte or the flush was sampled.
- Output queue:
  - Circular buffer with DEPTH entries.
  - out_valid = (occupancy != 0). out_data and out_keep are the head entry, driven from registers with no combinational path from inputs.
  - Pop when out_valid & out_ready. out_data and out_keep are held stable while out_valid=1 and out_ready=0.
  - Push and pop in the same cycle are both performed; occupancy is unchanged. This applies even when full: the pop frees the slot, so the push succeeds.
  - Push while full without a pop: the word is dropped, overflow is set and stays 1 until reset, and cnt is still reset to 0.
  - Pointers wrap modulo DEPTH.
  - out_data and out_keep read 0 when empty.
- No output depends combinationally on any input.

Decomposition:
- Shared package byte_word_packer_pkg holds:
  - BYTE_W=8, WORD_W=32, LANES=4.
  - The keep-mask encoding function keep_from_count(cnt).
- One natural sub-module, word_queue: a synchronous single-clock FIFO with push/pop/full/empty, parameterised by DEPTH and width 36 (32 data + 4 keep).
- The packer top holds only the assembly register, cnt, flush logic and the overflow flag.

Test Plan:
- Full word: after reset, bytes 87, 56, 9, 13 on four consecutive cycles with out_ready=1 → one cycle after the fourth byte, out_valid=1, out_data=0x0D093857, out_keep=4'b1111. Out_valid drops the next cycle.
- Flush of partial word: bytes 85 then 139, with flush=1 on the cycle carrying 139 → out_data=0x00008B55, out_keep=4'b0011. Then cnt=0: a following byte 51 plus flush yields 0x00000033, keep 4'b0001.
- Idle gaps: bytes 1 and 2, five idle cycles, then bytes 3 and 4 → a single word 0x04030201 and no spurious out_valid during the gap. A flush with cnt=0 produces nothing.
- Backpressure and overflow, DEPTH=2, out_ready=0: feed 12 bytes 0x00..0x0B →
  - two words 0x03020100 and 0x07060504 are held stable;
  - the third word is dropped and overflow=1;
  - raising out_ready drains exactly two words in order, and overflow stays 1.
- Simultaneous push and pop at full, DEPTH=2: queue full, out_ready=1 on the same cycle a fourth byte completes a word → no overflow, occupancy stays 2, words drain in order.
- Mid-operation reset: two bytes assembled and one word queued, then rst=1 for one cycle → out_valid=0 and overflow=0. Subsequent bytes 0xAA, 0xBB, 0xCC, 0xDD give 0xDDCCBBAA with no residue from before the reset.

Source files
------------

// File: rtl/byte_word_packer_pkg.sv
// Shared widths and keep-mask helper for the byte-to-word packer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package byte_word_packer_pkg;

    localparam int BYTE_W  = 8;
    localparam int WORD_W  = 32;
    localparam int LANES   = 4;
    localparam int ENTRY_W = WORD_W + LANES;

    // Contiguous low-lane mask for n valid bytes (n = 0..4).
    function automatic logic [LANES-1:0] keep_from_count(input logic [2:0] n);
        keep_from_count = LANES'((5'b1 << n) - 5'b1);
    endfunction

endpackage

// File: rtl/byte_word_packer_word_queue.sv
// Single-clock circular FIFO holding packed words with their keep masks.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: push while full is ignored unless a pop frees the slot in the same cycle.
module word_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_dat
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    // Head comes straight from registers; reads zero when nothing is queued.
    assign head_dat = empty ? '0 : mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy; a pop frees a full slot for a same-cycle push.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: unoccupied entries are masked at the head.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/byte_word_packer.sv
// Packs a byte stream little-endian into 32-bit words with keep masks; flush emits partial words.
// Latency: word appears on out_valid one cycle after its last byte or flush is sampled.
// Backpressure: none on input; out_ready pops the queue, words pushed into a full queue are dropped and flagged.
module byte_word_packer
    import byte_word_packer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              flush,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    output logic [LANES-1:0]  out_keep,
    output logic              overflow
);

    logic [1:0]          cnt_q, cnt_d;
    logic [WORD_W-1:0]   asm_q, asm_d;
    logic                overflow_q, overflow_d;
    logic [WORD_W-1:0]   merged;
    logic [2:0]          n_bytes;
    logic                push_vld;
    logic [ENTRY_W-1:0]  push_dat;
    logic                q_full;
    logic                q_empty;
    logic                pop_vld;
    logic [ENTRY_W-1:0]  head_dat;

    assign pop_vld   = ~q_empty & out_ready;
    assign out_valid = ~q_empty;
    assign out_keep  = head_dat[ENTRY_W-1 -: LANES];
    assign out_data  = head_dat[WORD_W-1:0];
    assign overflow  = overflow_q;

    // Merge the incoming byte into its lane first, then decide whether the word leaves.
    always_comb begin
        merged   = asm_q;
        n_bytes  = {1'b0, cnt_q};
        cnt_d    = cnt_q;
        asm_d    = asm_q;
        push_vld = 1'b0;
        push_dat = '0;
        if (in_valid) begin
            case (cnt_q)
                2'd0:    merged[7:0]   = in_data;
                2'd1:    merged[15:8]  = in_data;
                2'd2:    merged[23:16] = in_data;
                default: merged[31:24] = in_data;
            endcase
            n_bytes = {1'b0, cnt_q} + 3'd1;
        end
        if ((n_bytes == 3'd4) || (flush && (n_bytes != 3'd0))) begin
            push_vld = 1'b1;
            push_dat = {keep_from_count(n_bytes), merged};
            cnt_d    = 2'd0;
            asm_d    = '0;
        end else begin
            cnt_d = n_bytes[1:0];
            asm_d = merged;
        end
    end

    // Overflow latches on any push the queue cannot take; only reset clears it.
    always_comb begin
        overflow_d = overflow_q | (push_vld & q_full & ~pop_vld);
    end

    // Assembly state and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= 2'd0;
            asm_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            asm_q      <= asm_d;
            overflow_q <= overflow_d;
        end
    end

    word_queue #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_word_queue (
        .clk      (clk),
        .rst      (rst),
        .push     (push_vld),
        .push_dat (push_dat),
        .pop      (pop_vld),
        .full     (q_full),
        .empty    (q_empty),
        .head_dat (head_dat)
    );

endmodule

// File: tb/tb_byte_word_packer.sv
module tb_byte_word_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        flush;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    byte_word_packer #(.DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .flush     (flush),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Apply inputs for one cycle; return 1 time unit after the edge so outputs are settled.
    task automatic cyc(input logic v, input logic [7:0] d, input logic f);
        in_valid = v;
        in_data  = v ? d : 8'hxx;
        flush    = f;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 00000000", out_data); end
        checks++; if (out_keep !== 4'h0) begin errors++; $display("FAIL reset_keep got %b exp 0000", out_keep); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
    endtask

    task automatic test_full_word;
        out_ready = 1'b1;
        cyc(1'b1, 8'd87, 1'b0);
        cyc(1'b1, 8'd56, 1'b0);
        cyc(1'b1, 8'd9, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_early_valid got %b exp 0", out_valid); end
        cyc(1'b1, 8'd13, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_valid got %b exp 1", out_valid); end
        checks++; if (out_data !== 32'h0D093857) begin errors++; $display("FAIL full_data got %h exp 0d093857", out_data); end
        checks++; if (out_keep !== 4'b1111) begin errors++; $display("FAIL full_keep got %b exp 1111", out_keep); end
        cyc(1'b0, 8'h00, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_drop_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_flush;
        out_ready = 1'b1;
        cyc(1'b1, 8'd85, 1'b0);
        cyc(1'b1, 8'd139, 1'b1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush2_valid got %b exp 1", out_valid); end
        checks++; if (out_data !== 32'h00008B55) begin errors++; $display("FAIL flush2_data got %h exp 00008b55", out_data); end
        checks++; if (out_keep !== 4'b0011) begin errors++; $display("FAIL flush2_keep got %b exp 0011", out_keep); end
        cyc(1'b1, 8'd51, 1'b1);
        checks++; if (out_data !== 32'h00000033) begin errors++; $display("FAIL flush1_data got %h exp 00000033", out_data); end
        checks++; if (out_keep !== 4'b0001) begin errors++; $display("FAIL flush1_keep got %b exp 0001", out_keep); end
        cyc(1'b0, 8'h00, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL flush_empty_data got %h exp 00000000", out_data); end
        checks++; if (out_keep !== 4'h0) begin errors++; $display("FAIL flush_empty_keep got %b exp 0000", out_keep); end
    endtask

    task automatic test_idle_gaps;
        out_ready = 1'b1;
        cyc(1'b1, 8'h01, 1'b0);
        cyc(1'b1, 8'h02, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 8'h00, 1'b0);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL gap_valid idle %0d got %b exp 0", i, out_valid); end
        end
        cyc(1'b1, 8'h03, 1'b0);
        cyc(1'b1, 8'h04, 1'b0);
        checks++; if (out_data !== 32'h04030201) begin errors++; $display("FAIL gap_data got %h exp 04030201", out_data); end
        checks++; if (out_keep !== 4'b1111) begin errors++; $display("FAIL gap_keep got %b exp 1111", out_keep); end
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL empty_flush_valid got %b exp 0", out_valid); end
        cyc(1'b0, 8'h00, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL empty_flush_late got %b exp 0", out_valid); end
    endtask

    task automatic test_push_pop_full;
        out_ready = 1'b0;
        for (int i = 0; i < 11; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0);
        checks++; if (out_data !== 32'h13121110) begin errors++; $display("FAIL pp_head got %h exp 13121110", out_data); end
        out_ready = 1'b1;
        cyc(1'b1, 8'h1B, 1'b0);
        out_ready = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pp_ovf got %b exp 0", overflow); end
        checks++; if (out_data !== 32'h17161514) begin errors++; $display("FAIL pp_head2 got %h exp 17161514", out_data); end
        out_ready = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);
        checks++; if (out_data !== 32'h1B1A1918) begin errors++; $display("FAIL pp_head3 got %h exp 1b1a1918", out_data); end
        cyc(1'b0, 8'h00, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pp_drained got %b exp 0", out_valid); end
    endtask

    task automatic test_overflow;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'(i), 1'b0);
        checks++; if (out_data !== 32'h03020100) begin errors++; $display("FAIL ovf_hold1 got %h exp 03020100", out_data); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", overflow); end
        for (int i = 8; i < 12; i++) cyc(1'b1, 8'(i), 1'b0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
        checks++; if (out_data !== 32'h03020100) begin errors++; $display("FAIL ovf_hold2 got %h exp 03020100", out_data); end
        out_ready = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);
        checks++; if (out_data !== 32'h07060504) begin errors++; $display("FAIL ovf_second got %h exp 07060504", out_data); end
        cyc(1'b0, 8'h00, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got %b exp 0", out_valid); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
    endtask

    task automatic test_mid_reset;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) cyc(1'b1, 8'(8'h21 + i), 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mr_pre_valid got %b exp 1", out_valid); end
        rst = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mr_valid got %b exp 0", out_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mr_ovf got %b exp 0", overflow); end
        out_ready = 1'b1;
        cyc(1'b1, 8'hAA, 1'b0);
        cyc(1'b1, 8'hBB, 1'b0);
        cyc(1'b1, 8'hCC, 1'b0);
        cyc(1'b1, 8'hDD, 1'b0);
        checks++; if (out_data !== 32'hDDCCBBAA) begin errors++; $display("FAIL mr_data got %h exp ddccbbaa", out_data); end
        checks++; if (out_keep !== 4'b1111) begin errors++; $display("FAIL mr_keep got %b exp 1111", out_keep); end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        flush     = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_full_word();
        test_flush();
        test_idle_gaps();
        test_push_pop_full();
        test_overflow();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
